// File: rtl/pulse_train_gen_if.sv
// Burst request/config and generated waveform bundle for pulse_train_gen.
interface pulse_train_gen_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] high_len;
    logic [WIDTH-1:0] low_len;
    logic [WIDTH-1:0] count;
    logic             signal;
    logic             busy;
    logic             done;

    // Controller side: issues requests and config, observes the waveform.
    modport master (
        output start, stop, high_len, low_len, count,
        input  signal, busy, done
    );

    // Generator side.
    modport slave (
        input  start, stop, high_len, low_len, count,
        output signal, busy, done
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Pulse-train transmitter: bursts of C pulses, H cycles high, L cycles low between.
module pulse_train_gen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    pulse_train_gen_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] phase_q, phase_d;    // cycles spent in current phase, 1-based
    logic [WIDTH-1:0] remain_q, remain_d;  // pulses still to issue after the current one
    logic [WIDTH-1:0] h_q, h_d;
    logic [WIDTH-1:0] l_q, l_d;
    logic             signal_q, signal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign bus.signal = signal_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            remain_q <= '0;
            h_q      <= '0;
            l_q      <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            h_q      <= h_d;
            l_q      <= l_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        h_d      = h_q;
        l_d      = l_q;
        signal_d = signal_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                signal_d = 1'b0;
                busy_d   = 1'b0;
                if (bus.start && !bus.stop && (bus.count != '0)) begin
                    // Zero lengths are clamped so every pulse and gap is visible.
                    h_d      = (bus.high_len == '0) ? WIDTH'(1) : bus.high_len;
                    l_d      = (bus.low_len == '0) ? WIDTH'(1) : bus.low_len;
                    remain_d = bus.count - WIDTH'(1);
                    phase_d  = WIDTH'(1);
                    state_d  = S_HIGH;
                    signal_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_HIGH: begin
                if (bus.stop) begin
                    state_d  = S_IDLE;
                    signal_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (phase_q == h_q) begin
                    signal_d = 1'b0;
                    phase_d  = WIDTH'(1);
                    if (remain_q == '0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOW;
                    end
                end else begin
                    phase_d = phase_q + WIDTH'(1);
                end
            end
            S_LOW: begin
                if (bus.stop) begin
                    state_d  = S_IDLE;
                    signal_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (phase_q == l_q) begin
                    state_d  = S_HIGH;
                    signal_d = 1'b1;
                    phase_d  = WIDTH'(1);
                    remain_d = remain_q - WIDTH'(1);
                end else begin
                    phase_d = phase_q + WIDTH'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                signal_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen with a timing-formula reference model.
module tb_pulse_train_gen;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pulse_train_gen_if #(.WIDTH(WIDTH)) bus ();

    pulse_train_gen #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a burst is described by its start edge and latched H, L, C;
    // outputs after each edge follow directly from the elapsed cycle count t.
    bit exp_signal = 1'b0;
    bit exp_busy   = 1'b0;
    bit exp_done   = 1'b0;
    bit m_active   = 1'b0;
    int m_t = 0;
    int m_h = 0;
    int m_l = 0;
    int m_c = 0;

    always @(posedge clk) begin
        exp_done = 1'b0;
        if (rst) begin
            m_active   = 1'b0;
            exp_signal = 1'b0;
            exp_busy   = 1'b0;
        end else if (m_active) begin
            if (bus.stop) begin
                m_active   = 1'b0;
                exp_signal = 1'b0;
                exp_busy   = 1'b0;
            end else begin
                m_t = m_t + 1;
                if (m_t == m_c * m_h + (m_c - 1) * m_l) begin
                    m_active   = 1'b0;
                    exp_signal = 1'b0;
                    exp_busy   = 1'b0;
                    exp_done   = 1'b1;
                end else begin
                    exp_signal = (m_t % (m_h + m_l)) < m_h;
                    exp_busy   = 1'b1;
                end
            end
        end else if (bus.start && !bus.stop && bus.count != 0) begin
            m_active   = 1'b1;
            m_t        = 0;
            m_h        = (bus.high_len == 0) ? 1 : int'(bus.high_len);
            m_l        = (bus.low_len == 0) ? 1 : int'(bus.low_len);
            m_c        = int'(bus.count);
            exp_signal = 1'b1;
            exp_busy   = 1'b1;
        end
    end

    // Per-cycle compare against the model, plus event counters for literal checks.
    int  rises     = 0;
    int  busy_cnt  = 0;
    int  done_cnt  = 0;
    logic prev_sig = 1'b0;

    always @(negedge clk) begin
        checks = checks + 3;
        if (bus.signal !== exp_signal) begin
            errors = errors + 1;
            $display("FAIL signal t=%0t got=%b exp=%b", $time, bus.signal, exp_signal);
        end
        if (bus.busy !== exp_busy) begin
            errors = errors + 1;
            $display("FAIL busy t=%0t got=%b exp=%b", $time, bus.busy, exp_busy);
        end
        if (bus.done !== exp_done) begin
            errors = errors + 1;
            $display("FAIL done t=%0t got=%b exp=%b", $time, bus.done, exp_done);
        end
        if (bus.signal === 1'b1 && prev_sig === 1'b0) rises = rises + 1;
        if (bus.busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (bus.done === 1'b1) done_cnt = done_cnt + 1;
        prev_sig = bus.signal;
    end

    int s_r, s_b, s_d;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic snap();
        s_r = rises;
        s_b = busy_cnt;
        s_d = done_cnt;
    endtask

    task automatic expect_delta(input string name, input int er, input int eb, input int ed);
        checks = checks + 3;
        if (rises - s_r != er) begin
            errors = errors + 1;
            $display("FAIL %s rising_edges got=%0d exp=%0d", name, rises - s_r, er);
        end
        if (busy_cnt - s_b != eb) begin
            errors = errors + 1;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cnt - s_b, eb);
        end
        if (done_cnt - s_d != ed) begin
            errors = errors + 1;
            $display("FAIL %s done_pulses got=%0d exp=%0d", name, done_cnt - s_d, ed);
        end
    endtask

    task automatic expect_idle(input string name);
        checks = checks + 1;
        if ({bus.signal, bus.busy, bus.done} !== 3'b000) begin
            errors = errors + 1;
            $display("FAIL %s outputs got=%b%b%b exp=000", name, bus.signal, bus.busy, bus.done);
        end
    endtask

    task automatic cfg(input int h, input int l, input int c);
        bus.high_len = WIDTH'(h);
        bus.low_len  = WIDTH'(l);
        bus.count    = WIDTH'(c);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cfg(0, 0, 0);
        cyc(3);
        rst = 1'b0;
        expect_idle("reset");

        // Basic burst: H=2 L=3 C=3 -> 12 busy cycles, 3 edges, 1 done.
        snap();
        cfg(2, 3, 3); bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        checks = checks + 1;
        if (bus.signal !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL basic_latency signal got=%b exp=1", bus.signal);
        end
        cyc(15);
        expect_delta("basic", 3, 12, 1);

        // Zero clamps: 1,0,1 then done.
        snap();
        cfg(0, 0, 2); bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(6);
        expect_delta("clamp", 2, 3, 1);

        // count=0 start is ignored.
        snap();
        cfg(4, 4, 0); bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(3);
        expect_delta("count_zero", 0, 0, 0);

        // Mid-burst start with new config is ignored.
        snap();
        cfg(2, 3, 3); bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(3);
        cfg(5, 1, 7); bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(12);
        expect_delta("ignored_start", 3, 12, 1);

        // Back-to-back: three bursts of H=L=1 C=2 with one idle cycle between.
        snap();
        cfg(1, 1, 2); bus.start = 1'b1; cyc(12); bus.start = 1'b0; cyc(5);
        expect_delta("back_to_back", 6, 9, 3);

        // Abort during second HIGH of a C=4 burst.
        snap();
        cfg(2, 2, 4); bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(4);
        bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
        expect_idle("abort");
        cyc(10);
        expect_delta("abort", 2, 5, 0);

        // stop with start in IDLE drops the request.
        snap();
        cfg(1, 1, 3); bus.start = 1'b1; bus.stop = 1'b1; cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0; cyc(3);
        expect_delta("stop_start", 0, 0, 0);

        // Reset during LOW, then a fresh burst with new config.
        snap();
        cfg(1, 4, 3); bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(2);
        rst = 1'b1; cyc(1);
        expect_idle("reset_mid");
        rst = 1'b0; cyc(2);
        expect_delta("reset_mid", 1, 3, 0);
        snap();
        cfg(3, 1, 2); bus.start = 1'b1; cyc(1); bus.start = 1'b0; cyc(10);
        expect_delta("fresh_after_reset", 2, 7, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Synchronous pulse-train transmitter: on a one-cycle `start` request it drives a level output `signal` with a programmable number of high pulses, each of programmable high width, separated by programmable low gaps. It is the generating end of the rising-edge detection path. It produces clean, clock-aligned level waveforms, and each pulse yields exactly one rising edge for the `edge_detector` downstream. `busy` and `done` let a controller sequence back-to-back bursts.

## Interface
- `WIDTH`, default 8: width of the length and count fields and of the internal counters.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: burst request; sampled only when `busy`=0.
- `stop`  in  1: synchronous abort of the current burst.
- `high_len`  in  WIDTH: high-phase length in cycles; latched at start.
- `low_len`  in  WIDTH: low-gap length in cycles between pulses; latched at start.
- `count`  in  WIDTH: number of pulses in the burst; latched at start.
- `signal`  out  1: generated level waveform; registered.
- `busy`  out  1: burst in progress; registered.
- `done`  out  1: one-cycle pulse on normal burst completion; registered.

## Operation
- FSM states: IDLE, HIGH, LOW.
- Internal state: phase counter (WIDTH bits), remaining-pulse counter (WIDTH bits), latched H, L and C.
- Reset value of every output: `signal`=0, `busy`=0, `done`=0. Counters clear and the FSM returns to IDLE.
- **IDLE, `start`=1, `stop`=0, `count`≠0:**
  - Latch H = max(`high_len`,1), L = max(`low_len`,1), C = `count`.
  - Go to HIGH; `signal`=1, `busy`=1.
- **IDLE, `count`=0:** `start` is ignored. No state change, no `done`.
- **HIGH:**
  - `signal`=1 for exactly H cycles.
  - If this is the last pulse, go to IDLE: `signal`=0, `busy`=0, `done`=1 for one cycle.
  - Otherwise go to LOW with `signal`=0.
- **LOW:**
  - `signal`=0 for exactly L cycles, then go to HIGH.
  - The remaining-pulse count decrements on each HIGH entry.
- `start` while `busy`=1 is ignored; latched config is unaffected by input changes mid-burst.
- **`stop`=1 in HIGH or LOW:** next edge forces IDLE with `signal`=0 and `busy`=0. `done` is NOT asserted.
- **`stop` and `start` together in IDLE:** `stop` wins; the request is dropped.
- `rst` has priority over everything; reset mid-burst aborts it with no `done`.
- Counters never wrap. H, L ≤ 2^WIDTH−1, and the max(…,1) clamp guarantees every pulse is at least one cycle high and every gap at least one cycle low.

## Timing
- `start` sampled at edge k (`busy`=0): `signal` rises immediately after edge k. Latency is 1 edge.
- Pulse p (0-based) is high after edges k+p·(H+L) through k+p·(H+L)+H−1.
- Gaps are low for L cycles between pulses. There is no trailing gap after the last pulse.
- `busy` is high for exactly C·H + (C−1)·L cycles.
- `done` is high for the single cycle after edge k + C·H + (C−1)·L. On that same edge `signal` falls and `busy` drops.
- Back-to-back: `start` held high continuously is re-sampled on the edge after `busy` drops. `signal` is therefore low for exactly 1 cycle between bursts, so the rising edge is always detectable.
- `stop` sampled at edge s: `signal`=0 and `busy`=0 after edge s.
- `rst` sampled at edge r: all outputs 0 after edge r.

## Test plan
- **Basic burst:** `high_len`=2, `low_len`=3, `count`=3, `start` pulsed at edge k → `signal` high after k..k+1, k+5..k+6, k+10..k+11. `busy` high for 12 cycles. `done`=1 only after edge k+12. Exactly 3 rising edges.
- **Zero clamps and count=0:**
  - `high_len`=0, `low_len`=0, `count`=2 → pattern 1,0,1, then `done`.
  - `count`=0 with `start` → `busy`, `signal` and `done` all stay 0.
- **Ignored start:** `start` re-pulsed mid-burst with different lengths → waveform unchanged from the first config; one `done` only.
- **Back-to-back:** `start` held high, `high_len`=1, `low_len`=1, `count`=2 → `signal` 1,0,1,0,1,0,1…
  - `done` after each burst.
  - Exactly one low cycle between bursts.
- **Abort:**
  - `stop` during the second HIGH of a `count`=4 burst → `signal`=0 and `busy`=0 next edge; `done` never asserted.
  - `stop` together with `start` in IDLE → nothing starts.
- **Reset mid-burst:** `rst` asserted during LOW → all outputs 0 next edge.
  - A new `start` after `rst` deasserts runs a full fresh burst with the new config.
